uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Transmit side of the krv_e UART. Buffers bus writes in a small FIFO and
//  serialises each byte onto UART_TX as start, data (LSB first), optional parity, 1 stop.
//  Bit timing comes from the shared baud generator's oversample strobe.
//  UART_TX is the line the bench loops into uart_rx, so frame format matches uart_rx exactly.
// PARAMETERS
//  OVERSAMPLE  16  tx_sample_pulse strobes per bit period (>=2)
//  FIFO_DEPTH  4   tx holding FIFO entries (power of 2, >=2)
// PORTS
//  ACLK               in   1  system clock
//  ARESETn            in   1  asynchronous active-low reset
//  tx_sample_pulse    in   1  1-cycle oversample strobe from baud generator
//  data_bits          in   1  0 = 7 data bits, 1 = 8 data bits
//  parity_en          in   1  1 = append parity bit
//  parity_odd0_even1  in   1  0 = odd parity, 1 = even parity
//  tx_data_reg_wr     in   1  write strobe; pushes tx_data when FIFO not full
//  tx_data            in   8  byte to send
//  tx_ready           out  1  FIFO not full
//  tx_empty           out  1  FIFO empty and serialiser idle
//  tx_busy            out  1  frame in progress
//  overflow           out  1  1-cycle pulse: write dropped because FIFO full
//  UART_TX            out  1  serial line, idle high
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): UART_TX=1, state IDLE, FIFO flushed,
//   tx_ready=1, tx_empty=1, tx_busy=0, overflow=0, counters 0. No partial frame resumes.
//  FIFO: push on tx_data_reg_wr && !full; write when full -> data dropped, overflow=1
//   next cycle for one cycle. Push and pop in same cycle allowed, count unchanged.
//   Wrap-around pointers, log2(FIFO_DEPTH)+1 bit count.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: if FIFO non-empty, pop into shift reg, latch data_bits/parity_en/parity_odd0_even1
//    for the whole frame, go START same edge; UART_TX=0 from next cycle. Config changes
//    mid-frame do not affect the current frame.
//   Bit period: OVERSAMPLE tx_sample_pulse strobes counted by os_cnt (0..OVERSAMPLE-1);
//    state/bit advances on the strobe where os_cnt==OVERSAMPLE-1. The START bit is the
//    exception: it begins immediately on pop, not aligned to a strobe.
//   DATA: shift LSB first, 7 or 8 bits per latched data_bits; bit7 ignored in 7-bit mode.
//   PARITY (only if parity_en): even -> ^data, odd -> ~^data, over the sent bits only.
//   STOP: UART_TX=1 one bit period; then IDLE, or next byte's START the very next cycle
//    if FIFO non-empty (back-to-back frames, no extra idle).
//  tx_busy=1 in START..STOP; tx_empty=!tx_busy && count==0.
//  All outputs registered; UART_TX glitch-free.
// TESTING
//  (OVERSAMPLE=16, tx_sample_pulse tied 1, 8N1 unless stated)
//  T1 write 0x55 -> UART_TX 0,1,0,1,0,1,0,1,0,1 each 16 cycles (160 total);
//     tx_busy high 160 cycles.
//  T2 parity_en=1 even, write 0x07 -> parity bit 1; odd, write 0x07 -> parity bit 0;
//     frame 176 cycles.
//  T3 data_bits=0, write 0xFF -> start, seven 1s, stop; 144 cycles; uart_rx loopback
//     reads 0x7F.
//  T4 six writes on consecutive cycles from idle -> 6th dropped, overflow pulses once,
//     bytes 1-5 received back-to-back in order with no gaps.
//  T5 deassert ARESETn mid-DATA of a 3-byte burst -> UART_TX=1 immediately, tx_empty=1;
//     after release, line stays idle until next write.
//  T6 tx_sample_pulse every 4th cycle, write 0xA3 -> each bit lasts 64 cycles;
//     uart_rx loopback reads 0xA3, no parity_err.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART transmitter. Sends start, 7/8 data bits LSB first,
// optional parity and one stop bit, with bit timing taken from an oversample strobe.
module uart_tx_engine #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       tx_sample_pulse,
    input  logic       data_bits,
    input  logic       parity_en,
    input  logic       parity_odd0_even1,
    input  logic       tx_data_reg_wr,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       overflow,
    output logic       UART_TX
);

    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Frame format captured at pop so mid-frame config writes cannot corrupt a frame
    typedef struct packed {
        logic eight_bits;
        logic par_en;
        logic par_bit;
    } frame_cfg_t;

    state_t         state, state_d;
    logic           pop;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_cnt, fifo_cnt_d;
    logic           fifo_full, fifo_nempty, push;
    logic [7:0]     pop_byte, sent_byte;

    logic [OSW-1:0] os_cnt, os_cnt_d;
    logic [2:0]     bit_cnt, bit_cnt_d;
    logic [7:0]     shift, shift_d;
    frame_cfg_t     cfg, cfg_d;
    logic           bit_tick, last_bit;

    logic           line_d, busy_d, empty_d, ready_d, ovf_d;

    assign fifo_full   = (fifo_cnt == FULL_CNT);
    assign fifo_nempty = (fifo_cnt != '0);
    assign push        = tx_data_reg_wr && !fifo_full;
    assign pop_byte    = fifo_mem[rd_ptr];
    assign sent_byte   = {pop_byte[7] & data_bits, pop_byte[6:0]};
    assign bit_tick    = tx_sample_pulse && (os_cnt == OS_LAST);
    assign last_bit    = (bit_cnt == (cfg.eight_bits ? 3'd7 : 3'd6));

    // Holding FIFO storage; flushing is done by the pointer/count reset
    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt + CW'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state; a pop happens from IDLE or at the end of STOP for back-to-back frames
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_nempty) begin
                    state_d = S_START;
                    pop     = 1'b1;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick && last_bit) begin
                    state_d = cfg.par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (fifo_nempty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Serialiser datapath: oversample counter, bit counter, shift register, frame config
    always_comb begin
        os_cnt_d  = os_cnt;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        cfg_d     = cfg;
        if (pop) begin
            os_cnt_d         = '0;
            bit_cnt_d        = '0;
            shift_d          = pop_byte;
            cfg_d.eight_bits = data_bits;
            cfg_d.par_en     = parity_en;
            cfg_d.par_bit    = parity_odd0_even1 ? ^sent_byte : ~^sent_byte;
        end else if ((state != S_IDLE) && tx_sample_pulse) begin
            os_cnt_d = bit_tick ? '0 : os_cnt + OSW'(1);
            if ((state == S_DATA) && bit_tick) begin
                shift_d   = {1'b0, shift[7:1]};
                bit_cnt_d = bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            cfg     <= '0;
        end else begin
            os_cnt  <= os_cnt_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            cfg     <= cfg_d;
        end
    end

    // Output decode from the next state so registered outputs line up with the state
    always_comb begin
        line_d = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_d[0];
            S_PARITY: line_d = cfg_d.par_bit;
            default:  line_d = 1'b1;
        endcase
        empty_d = !busy_d && (fifo_cnt_d == '0);
        ready_d = (fifo_cnt_d != FULL_CNT);
        ovf_d   = tx_data_reg_wr && fifo_full;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            UART_TX  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_empty <= 1'b1;
            tx_ready <= 1'b1;
            overflow <= 1'b0;
        end else begin
            UART_TX  <= line_d;
            tx_busy  <= busy_d;
            tx_empty <= empty_d;
            tx_ready <= ready_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level reference model checked every cycle, plus
// directed frames whose line waveform is decoded and compared against literal values.
module tb_uart_tx_engine;

    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 4;

    logic       ACLK;
    logic       ARESETn;
    logic       tx_sample_pulse;
    logic       data_bits;
    logic       parity_en;
    logic       parity_odd0_even1;
    logic       tx_data_reg_wr;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_empty;
    logic       tx_busy;
    logic       overflow;
    logic       UART_TX;

    uart_tx_engine #(.OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .ACLK              (ACLK),
        .ARESETn           (ARESETn),
        .tx_sample_pulse   (tx_sample_pulse),
        .data_bits         (data_bits),
        .parity_en         (parity_en),
        .parity_odd0_even1 (parity_odd0_even1),
        .tx_data_reg_wr    (tx_data_reg_wr),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .tx_empty          (tx_empty),
        .tx_busy           (tx_busy),
        .overflow          (overflow),
        .UART_TX           (UART_TX)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Oversample strobe generator: every pdiv-th cycle, or random when prand is set
    int pdiv  = 1;
    bit prand = 1'b0;
    int pcnt  = 0;
    initial begin
        tx_sample_pulse = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            if (prand) begin
                tx_sample_pulse = ($urandom_range(0, 1) == 1);
            end else begin
                tx_sample_pulse = (pcnt == 0);
                pcnt = (pcnt + 1 >= pdiv) ? 0 : pcnt + 1;
            end
        end
    end

    // Reference model: queue of pending bytes and the current frame as a list of line levels
    logic [7:0] mq[$];
    bit         fb[$];
    int         bi = 0;
    int         pc = 0;
    bit         act = 1'b0;
    bit         e_ovf = 1'b0;
    bit         m_full;

    task automatic build_frame(input logic [7:0] b);
        int n    = data_bits ? 8 : 7;
        int ones = 0;
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            fb.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (parity_en) begin
            fb.push_back(parity_odd0_even1 ? (ones % 2 == 1) : (ones % 2 == 0));
        end
        fb.push_back(1'b1);
        act = 1'b1;
        bi  = 0;
        pc  = 0;
    endtask

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mq.delete();
            fb.delete();
            act   = 1'b0;
            bi    = 0;
            pc    = 0;
            e_ovf = 1'b0;
        end else begin
            m_full = (mq.size() >= FIFO_DEPTH);
            if (act && tx_sample_pulse) begin
                pc++;
                if (pc == OVERSAMPLE) begin
                    pc = 0;
                    bi++;
                    if (bi == fb.size()) act = 1'b0;
                end
            end
            if (!act && mq.size() > 0) build_frame(mq.pop_front());
            if (tx_data_reg_wr && !m_full) mq.push_back(tx_data);
            e_ovf = tx_data_reg_wr && m_full;
        end
    end

    always @(negedge ACLK) begin
        chk("UART_TX",  int'(UART_TX),  act ? int'(fb[bi]) : 1);
        chk("tx_busy",  int'(tx_busy),  int'(act));
        chk("tx_empty", int'(tx_empty), int'(!act && mq.size() == 0));
        chk("tx_ready", int'(tx_ready), int'(mq.size() < FIFO_DEPTH));
        chk("overflow", int'(overflow), int'(e_ovf));
    end

    // Line capture for the directed waveform checks
    bit cap_en = 1'b0;
    bit line_q[$];
    bit busy_q[$];
    bit ovf_q[$];
    always @(negedge ACLK) begin
        if (cap_en) begin
            line_q.push_back(UART_TX);
            busy_q.push_back(tx_busy);
            ovf_q.push_back(overflow);
        end
    end

    task automatic start_cap();
        line_q.delete();
        busy_q.delete();
        ovf_q.delete();
        cap_en = 1'b1;
    endtask

    function automatic int sample(input int idx);
        if (idx < 0 || idx >= line_q.size()) return -1;
        return int'(line_q[idx]);
    endfunction

    function automatic int find_level(input int from, input bit lvl);
        if (from < 0) return -1;
        for (int i = from; i < line_q.size(); i++) if (line_q[i] == lvl) return i;
        return -1;
    endfunction

    function automatic int count_busy();
        int c = 0;
        foreach (busy_q[i]) c += int'(busy_q[i]);
        return c;
    endfunction

    function automatic int count_ovf();
        int c = 0;
        foreach (ovf_q[i]) c += int'(ovf_q[i]);
        return c;
    endfunction

    // Independent receiver: samples mid-bit from a start index, -1 if samples run out
    function automatic int decode(input int base, input int p, input int n);
        int v = 0;
        int s;
        for (int j = 0; j < n; j++) begin
            s = sample(base + p * (j + 1) + p / 2);
            if (s < 0) return -1;
            v |= s << j;
        end
        return v;
    endfunction

    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr_byte(input logic [7:0] b);
        tx_data        = b;
        tx_data_reg_wr = 1'b1;
        cyc();
        tx_data_reg_wr = 1'b0;
    endtask

    int         fe, a, b, c;
    logic [9:0] pat;

    initial begin
        ARESETn           = 1'b0;
        tx_data_reg_wr    = 1'b0;
        tx_data           = 8'h00;
        data_bits         = 1'b1;
        parity_en         = 1'b0;
        parity_odd0_even1 = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("rst_uart_tx",  int'(UART_TX),  1);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_tx_empty", int'(tx_empty), 1);
        chk("rst_tx_busy",  int'(tx_busy),  0);
        cyc();
        ARESETn = 1'b1;
        run(3);

        // 8N1 0x55: alternating line, 160 busy cycles
        start_cap();
        wr_byte(8'h55);
        run(200);
        chk("t1_busy_cycles", count_busy(), 160);
        fe  = find_level(0, 1'b0);
        pat = 10'h2AA;
        for (int k = 0; k < 10; k++) chk("t1_line_bit", sample(fe + 16 * k + 8), int'(pat[k]));
        chk("t1_decode", decode(fe, 16, 8), 8'h55);

        // Parity on 0x07: even -> 1, odd -> 0, 176-cycle frame
        parity_en = 1'b1;
        parity_odd0_even1 = 1'b1;
        start_cap();
        wr_byte(8'h07);
        run(200);
        fe = find_level(0, 1'b0);
        chk("t2_even_parity", sample(fe + 16 * 9 + 8), 1);
        chk("t2_busy_cycles", count_busy(), 176);
        parity_odd0_even1 = 1'b0;
        start_cap();
        wr_byte(8'h07);
        run(200);
        fe = find_level(0, 1'b0);
        chk("t2_odd_parity", sample(fe + 16 * 9 + 8), 0);
        chk("t2_odd_stop", sample(fe + 16 * 10 + 8), 1);
        parity_en = 1'b0;
        parity_odd0_even1 = 1'b1;

        // 7-bit mode: bit 7 is not sent
        data_bits = 1'b0;
        start_cap();
        wr_byte(8'hFF);
        run(180);
        fe = find_level(0, 1'b0);
        chk("t3_busy_cycles", count_busy(), 144);
        chk("t3_decode", decode(fe, 16, 7), 8'h7F);
        chk("t3_stop", sample(fe + 16 * 8 + 8), 1);
        data_bits = 1'b1;

        // Six consecutive writes: sixth dropped, five frames back to back
        start_cap();
        for (int k = 1; k <= 6; k++) begin
            tx_data        = 8'(k * 17);
            tx_data_reg_wr = 1'b1;
            cyc();
        end
        tx_data_reg_wr = 1'b0;
        run(900);
        chk("t4_overflow_pulses", count_ovf(), 1);
        chk("t4_busy_cycles", count_busy(), 800);
        fe = find_level(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t4_decode", decode(fe + 160 * k, 16, 8), (k + 1) * 17);
            chk("t4_stop", sample(fe + 160 * k + 9 * 16 + 8), 1);
        end

        // Reset in the middle of a data bit of a 3-byte burst
        wr_byte(8'h00);
        wr_byte(8'h00);
        wr_byte(8'h00);
        run(16 * 4 + 5);
        chk("t5_pre_reset_line", int'(UART_TX), 0);
        ARESETn = 1'b0;
        #1;
        chk("t5_reset_line", int'(UART_TX), 1);
        chk("t5_reset_empty", int'(tx_empty), 1);
        run(3);
        ARESETn = 1'b1;
        start_cap();
        run(200);
        chk("t5_line_lows", int'(find_level(0, 1'b0) >= 0), 0);
        chk("t5_busy_cycles", count_busy(), 0);

        // Strobe every 4th cycle: 64-cycle bits
        pdiv = 4;
        start_cap();
        wr_byte(8'hA3);
        run(64 * 10 + 80);
        fe = find_level(0, 1'b0);
        chk("t6_decode", decode(fe - 3, 64, 8), 8'hA3);
        chk("t6_stop", sample(fe - 3 + 64 * 9 + 32), 1);
        a = find_level(fe, 1'b1);
        b = find_level(a, 1'b0);
        c = find_level(b, 1'b1);
        chk("t6_ones_run", b - a, 128);
        chk("t6_zeros_run", c - b, 192);
        cap_en = 1'b0;

        // Randomised traffic, config churn, strobe patterns and resets
        for (int seg = 0; seg < 12; seg++) begin
            pdiv  = $urandom_range(1, 3);
            prand = (seg % 4 == 3);
            for (int t = 0; t < 500; t++) begin
                tx_data        = 8'($urandom);
                tx_data_reg_wr = ($urandom_range(0, 15) == 0) || (seg % 3 == 1 && $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    data_bits         = 1'($urandom);
                    parity_en         = 1'($urandom);
                    parity_odd0_even1 = 1'($urandom);
                end
                if ($urandom_range(0, 799) == 0) begin
                    ARESETn = 1'b0;
                    cyc();
                    cyc();
                    ARESETn = 1'b1;
                end
                cyc();
            end
        end
        tx_data_reg_wr = 1'b0;
        prand = 1'b0;
        pdiv  = 1;
        for (int t = 0; t < 3000 && !tx_empty; t++) cyc();
        chk("drain_empty", int'(tx_empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
